// File: rtl/hash_pkg.sv
// Shared types for the hash-table request sequencer: op codes, response status codes,
// sequencer states and the controller flag bundle.
package hash_pkg;

    typedef enum logic [1:0] {
        OP_NOTHING = 2'b00,
        OP_READ    = 2'b01,
        OP_WRITE   = 2'b10,
        OP_DELETE  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_OK            = 3'd0,
        ST_NOT_FOUND     = 3'd1,
        ST_NO_SPACE      = 3'd2,
        ST_KEY_PRESENT   = 3'd3,
        ST_NO_DEL_TARGET = 3'd4
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_EXEC = 2'd2,
        S_RESP = 2'd3
    } state_e;

    typedef struct packed {
        logic key_already_present;
        logic no_write_space;
        logic no_element_found;
        logic no_deletion_target;
    } flags_t;

endpackage

// File: rtl/hash_status_encoder.sv
// Maps an op and the controller flags to a response status; write flags are prioritised
// KEY_PRESENT over NO_SPACE, and flags unrelated to the op are ignored.
module hash_status_encoder
    import hash_pkg::*;
(
    input  op_e     op,
    input  flags_t  flags,
    output status_e status_c
);

    always_comb begin
        status_c = ST_OK;
        case (op)
            OP_WRITE: begin
                if (flags.key_already_present) begin
                    status_c = ST_KEY_PRESENT;
                end else if (flags.no_write_space) begin
                    status_c = ST_NO_SPACE;
                end
            end
            OP_READ: begin
                if (flags.no_element_found) begin
                    status_c = ST_NOT_FOUND;
                end
            end
            OP_DELETE: begin
                if (flags.no_deletion_target) begin
                    status_c = ST_NO_DEL_TARGET;
                end
            end
            default: status_c = ST_OK;
        endcase
    end

endmodule

// File: rtl/hash_request_sequencer.sv
// Client-side initiator for the hash-table controller: IDLE -> WAIT -> EXEC -> RESP.
// Optional saturating op/failure counters are enabled by defining HASH_SEQ_STATS_EN.
module hash_request_sequencer
    import hash_pkg::*;
#(
    parameter int unsigned KEY_WIDTH    = 2,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned STAT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [1:0]            req_op_i,
    input  logic [KEY_WIDTH-1:0]  req_key_i,
    input  logic [DATA_WIDTH-1:0] req_data_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output status_e               rsp_status_o,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic [KEY_WIDTH-1:0]  ctl_key_o,
    output logic [DATA_WIDTH-1:0] ctl_data_o,
    output logic [1:0]            ctl_op_o,
    input  logic [DATA_WIDTH-1:0] ctl_read_data_i,
    input  logic                  ctl_no_deletion_target_i,
    input  logic                  ctl_no_write_space_i,
    input  logic                  ctl_no_element_found_i,
    input  logic                  ctl_key_already_present_i,
    output logic                  busy_o
`ifdef HASH_SEQ_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] stat_reads_o,
    output logic [STAT_WIDTH-1:0] stat_writes_o,
    output logic [STAT_WIDTH-1:0] stat_deletes_o,
    output logic [STAT_WIDTH-1:0] stat_fails_o
`endif
);

    localparam int unsigned CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT =
        CNT_W'((READ_LATENCY > 0) ? (READ_LATENCY - 1) : 0);

    state_e           state;
    op_e              op_q;
    logic [CNT_W-1:0] cnt;
    flags_t           flags_c;
    status_e          status_c;

    assign flags_c = '{key_already_present: ctl_key_already_present_i,
                       no_write_space:      ctl_no_write_space_i,
                       no_element_found:    ctl_no_element_found_i,
                       no_deletion_target:  ctl_no_deletion_target_i};

    hash_status_encoder u_status_encoder (
        .op       (op_q),
        .flags    (flags_c),
        .status_c (status_c)
    );

    // Sequencer FSM; ctl_op_o is loaded on entry to EXEC so it is nonzero for that cycle only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            op_q         <= OP_NOTHING;
            cnt          <= '0;
            req_ready_o  <= 1'b1;
            busy_o       <= 1'b0;
            rsp_valid_o  <= 1'b0;
            rsp_status_o <= ST_OK;
            rsp_data_o   <= '0;
            ctl_key_o    <= '0;
            ctl_data_o   <= '0;
            ctl_op_o     <= 2'b00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid_i && req_ready_o && (op_e'(req_op_i) != OP_NOTHING)) begin
                        op_q        <= op_e'(req_op_i);
                        ctl_key_o   <= req_key_i;
                        ctl_data_o  <= req_data_i;
                        req_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        if (READ_LATENCY == 0) begin
                            state    <= S_EXEC;
                            ctl_op_o <= req_op_i;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        state    <= S_EXEC;
                        ctl_op_o <= op_q;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_EXEC: begin
                    ctl_op_o     <= 2'b00;
                    rsp_valid_o  <= 1'b1;
                    rsp_status_o <= status_c;
                    rsp_data_o   <= ((op_q == OP_READ) && (status_c == ST_OK)) ?
                                    ctl_read_data_i : '0;
                    state        <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o  <= 1'b0;
                        rsp_status_o <= ST_OK;
                        rsp_data_o   <= '0;
                        ctl_key_o    <= '0;
                        ctl_data_o   <= '0;
                        req_ready_o  <= 1'b1;
                        busy_o       <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef HASH_SEQ_STATS_EN
    // Saturating per-kind op counters, updated once per EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_reads_o   <= '0;
            stat_writes_o  <= '0;
            stat_deletes_o <= '0;
            stat_fails_o   <= '0;
        end else if (state == S_EXEC) begin
            if ((op_q == OP_READ) && (stat_reads_o != '1)) begin
                stat_reads_o <= stat_reads_o + 1'b1;
            end
            if ((op_q == OP_WRITE) && (stat_writes_o != '1)) begin
                stat_writes_o <= stat_writes_o + 1'b1;
            end
            if ((op_q == OP_DELETE) && (stat_deletes_o != '1)) begin
                stat_deletes_o <= stat_deletes_o + 1'b1;
            end
            if ((status_c != ST_OK) && (stat_fails_o != '1)) begin
                stat_fails_o <= stat_fails_o + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hash_request_sequencer.sv
// Bench for hash_request_sequencer: a READ_LATENCY=1 and a READ_LATENCY=0 instance share the
// request/controller inputs; sel picks which one a transaction targets.
module tb_hash_request_sequencer;
    import hash_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid1, req_valid0, rsp_ready1, rsp_ready0;
    logic [1:0]  req_op, req_key;
    logic [31:0] req_data, rd_data;
    logic        kp, ns, nf, nd;

    logic        req_ready1, rsp_valid1, busy1;
    logic        req_ready0, rsp_valid0, busy0;
    status_e     rsp_status1, rsp_status0;
    logic [31:0] rsp_data1, rsp_data0, ctl_data1, ctl_data0;
    logic [1:0]  ctl_key1, ctl_key0, ctl_op1, ctl_op0;
`ifdef HASH_SEQ_STATS_EN
    logic [15:0] st_rd1, st_wr1, st_del1, st_fail1;
    logic [15:0] st_rd0, st_wr0, st_del0, st_fail0;
`endif

    hash_request_sequencer #(.KEY_WIDTH(2), .DATA_WIDTH(32), .READ_LATENCY(1), .STAT_WIDTH(16)) dut1 (
        .clk(clk), .rst(rst), .req_valid_i(req_valid1), .req_ready_o(req_ready1),
        .req_op_i(req_op), .req_key_i(req_key), .req_data_i(req_data),
        .rsp_valid_o(rsp_valid1), .rsp_ready_i(rsp_ready1), .rsp_status_o(rsp_status1),
        .rsp_data_o(rsp_data1), .ctl_key_o(ctl_key1), .ctl_data_o(ctl_data1), .ctl_op_o(ctl_op1),
        .ctl_read_data_i(rd_data), .ctl_no_deletion_target_i(nd), .ctl_no_write_space_i(ns),
        .ctl_no_element_found_i(nf), .ctl_key_already_present_i(kp), .busy_o(busy1)
`ifdef HASH_SEQ_STATS_EN
        , .stat_reads_o(st_rd1), .stat_writes_o(st_wr1), .stat_deletes_o(st_del1), .stat_fails_o(st_fail1)
`endif
    );

    hash_request_sequencer #(.KEY_WIDTH(2), .DATA_WIDTH(32), .READ_LATENCY(0), .STAT_WIDTH(16)) dut0 (
        .clk(clk), .rst(rst), .req_valid_i(req_valid0), .req_ready_o(req_ready0),
        .req_op_i(req_op), .req_key_i(req_key), .req_data_i(req_data),
        .rsp_valid_o(rsp_valid0), .rsp_ready_i(rsp_ready0), .rsp_status_o(rsp_status0),
        .rsp_data_o(rsp_data0), .ctl_key_o(ctl_key0), .ctl_data_o(ctl_data0), .ctl_op_o(ctl_op0),
        .ctl_read_data_i(rd_data), .ctl_no_deletion_target_i(nd), .ctl_no_write_space_i(ns),
        .ctl_no_element_found_i(nf), .ctl_key_already_present_i(kp), .busy_o(busy0)
`ifdef HASH_SEQ_STATS_EN
        , .stat_reads_o(st_rd0), .stat_writes_o(st_wr0), .stat_deletes_o(st_del0), .stat_fails_o(st_fail0)
`endif
    );

    logic        sel;
    logic        m_req_ready, m_rsp_valid, m_busy;
    logic [2:0]  m_rsp_status;
    logic [31:0] m_rsp_data, m_ctl_data;
    logic [1:0]  m_ctl_key, m_ctl_op;
    assign m_req_ready  = sel ? req_ready1 : req_ready0;
    assign m_rsp_valid  = sel ? rsp_valid1 : rsp_valid0;
    assign m_busy       = sel ? busy1 : busy0;
    assign m_rsp_status = sel ? 3'(rsp_status1) : 3'(rsp_status0);
    assign m_rsp_data   = sel ? rsp_data1 : rsp_data0;
    assign m_ctl_data   = sel ? ctl_data1 : ctl_data0;
    assign m_ctl_key    = sel ? ctl_key1 : ctl_key0;
    assign m_ctl_op     = sel ? ctl_op1 : ctl_op0;

    typedef struct {
        logic        sel;
        logic [1:0]  op;
        logic [1:0]  key;
        logic [31:0] data;
        logic [31:0] rdata;
        logic [3:0]  flags;      // {key_present, no_space, not_found, no_del_target}
        logic [2:0]  exp_status;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        logic [2:0]  st;
        logic [31:0] d;
    } exp_t;

    vec_t vecs[12];
    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_valid(input logic v);
        if (sel) req_valid1 = v; else req_valid0 = v;
    endtask

    task automatic set_ready(input logic v);
        if (sel) rsp_ready1 = v; else rsp_ready0 = v;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic release_rsp();
        set_ready(1'b1);
        tick();
        set_ready(1'b0);
        #1;
        chk("rsp_valid_after_release", 64'(m_rsp_valid), 64'd0);
        chk("req_ready_after_release", 64'(m_req_ready), 64'd1);
        chk("ctl_key_after_release", 64'(m_ctl_key), 64'd0);
    endtask

    // Drive one op at a negedge, then follow it to the response.
    task automatic run_op(input vec_t v, input logic hold);
        int   lat;
        int   cyc;
        int   pulses;
        logic [1:0] seen_op;
        exp_t e;
        lat = v.sel ? 1 : 0;
        sel = v.sel;
        req_op = v.op; req_key = v.key; req_data = v.data; rd_data = v.rdata;
        {kp, ns, nf, nd} = v.flags;
        set_valid(1'b1);
        #1;
        chk("req_ready_idle", 64'(m_req_ready), 64'd1);
        sb.push_back('{v.exp_status, v.exp_data});
        tick();
        set_valid(1'b0);
        cyc = 1; pulses = 0; seen_op = 2'b00;
        while (!m_rsp_valid && cyc < 20) begin
            if (m_ctl_op != 2'b00) begin
                pulses++;
                seen_op = m_ctl_op;
                chk("ctl_key_exec", 64'(m_ctl_key), 64'(v.key));
                chk("ctl_data_exec", 64'(m_ctl_data), 64'(v.data));
            end
            tick();
            cyc++;
        end
        chk("rsp_latency", 64'(cyc), 64'(lat + 2));
        chk("ctl_op_pulses", 64'(pulses), 64'd1);
        chk("ctl_op_value", 64'(seen_op), 64'(v.op));
        e = sb.pop_front();
        chk("rsp_status", 64'(m_rsp_status), 64'(e.st));
        chk("rsp_data", 64'(m_rsp_data), 64'(e.d));
        if (!hold) release_rsp();
    endtask

    initial begin
        logic bad;
        vec_t bp;
        vecs[0]  = '{1'b1, OP_WRITE,  2'd1, 32'hDEADBEEF, 32'h0,        4'b0000, ST_OK,            32'h0};
        vecs[1]  = '{1'b1, OP_READ,   2'd1, 32'h0,        32'hDEADBEEF, 4'b0000, ST_OK,            32'hDEADBEEF};
        vecs[2]  = '{1'b1, OP_WRITE,  2'd2, 32'h11112222, 32'h0,        4'b1100, ST_KEY_PRESENT,   32'h0};
        vecs[3]  = '{1'b1, OP_DELETE, 2'd1, 32'h0,        32'hCAFEF00D, 4'b0001, ST_NO_DEL_TARGET, 32'h0};
        vecs[4]  = '{1'b1, OP_WRITE,  2'd3, 32'h00000005, 32'h0,        4'b0100, ST_NO_SPACE,      32'h0};
        vecs[5]  = '{1'b1, OP_READ,   2'd3, 32'h0,        32'h12345678, 4'b0010, ST_NOT_FOUND,     32'h0};
        vecs[6]  = '{1'b1, OP_READ,   2'd2, 32'h0,        32'hA5A5A5A5, 4'b1101, ST_OK,            32'hA5A5A5A5};
        vecs[7]  = '{1'b1, OP_DELETE, 2'd0, 32'h0,        32'h00000077, 4'b1110, ST_OK,            32'h0};
        vecs[8]  = '{1'b0, OP_READ,   2'd0, 32'h0,        32'h00000099, 4'b0010, ST_NOT_FOUND,     32'h0};
        vecs[9]  = '{1'b0, OP_READ,   2'd1, 32'h0,        32'h00000099, 4'b0010, ST_NOT_FOUND,     32'h0};
        vecs[10] = '{1'b0, OP_READ,   2'd2, 32'h0,        32'h00000099, 4'b0010, ST_NOT_FOUND,     32'h0};
        vecs[11] = '{1'b0, OP_WRITE,  2'd3, 32'h0BADCAFE, 32'h0,        4'b0000, ST_OK,            32'h0};

        sel = 1'b1;
        rst = 1'b1;
        req_valid1 = 1'b0; req_valid0 = 1'b0; rsp_ready1 = 1'b0; rsp_ready0 = 1'b0;
        req_op = 2'b00; req_key = 2'b00; req_data = 32'h0; rd_data = 32'h0;
        {kp, ns, nf, nd} = 4'b0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_req_ready1", 64'(req_ready1), 64'd1);
        chk("reset_req_ready0", 64'(req_ready0), 64'd1);
        chk("reset_outputs1", 64'({rsp_valid1, busy1, 3'(rsp_status1), ctl_op1, ctl_key1}), 64'd0);
        chk("reset_data1", 64'({rsp_data1, ctl_data1}), 64'd0);
        chk("reset_outputs0", 64'({rsp_valid0, busy0, 3'(rsp_status0), ctl_op0, ctl_key0}), 64'd0);

        // Op 00 is consumed without a response.
        @(negedge clk);
        sel = 1'b1; req_op = OP_NOTHING; req_key = 2'd3; set_valid(1'b1);
        tick();
        set_valid(1'b0);
        #1;
        chk("nop_busy", 64'(m_busy), 64'd0);
        chk("nop_ready", 64'(m_req_ready), 64'd1);
        bad = 1'b0;
        repeat (4) begin
            tick();
            if (m_rsp_valid || m_ctl_op != 2'b00 || m_busy) bad = 1'b1;
        end
        chk("nop_no_response", 64'(bad), 64'd0);

        for (int i = 0; i < 12; i++) run_op(vecs[i], 1'b0);

`ifdef HASH_SEQ_STATS_EN
        chk("stat_reads0", 64'(st_rd0), 64'd3);
        chk("stat_writes0", 64'(st_wr0), 64'd1);
        chk("stat_deletes0", 64'(st_del0), 64'd0);
        chk("stat_fails0", 64'(st_fail0), 64'd3);
        chk("stat_reads1", 64'(st_rd1), 64'd3);
        chk("stat_writes1", 64'(st_wr1), 64'd3);
        chk("stat_deletes1", 64'(st_del1), 64'd2);
        chk("stat_fails1", 64'(st_fail1), 64'd4);
`endif

        // Backpressure: response held stable, new request refused, and not accepted on exit.
        bp = '{1'b1, OP_READ, 2'd2, 32'h0, 32'h0F0F0F0F, 4'b0000, ST_OK, 32'h0F0F0F0F};
        run_op(bp, 1'b1);
        req_op = OP_WRITE; req_key = 2'd1; rd_data = 32'h33333333; {kp, ns, nf, nd} = 4'b1111;
        set_valid(1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_rsp_valid", 64'(m_rsp_valid), 64'd1);
            chk("hold_rsp_status", 64'(m_rsp_status), 64'(ST_OK));
            chk("hold_rsp_data", 64'(m_rsp_data), 64'h0F0F0F0F);
            chk("hold_req_ready", 64'(m_req_ready), 64'd0);
        end
        set_ready(1'b1);
        tick();
        set_ready(1'b0);
        chk("bp_exit_rsp_valid", 64'(m_rsp_valid), 64'd0);
        chk("bp_exit_req_ready", 64'(m_req_ready), 64'd1);
        chk("bp_exit_not_accepted", 64'(m_busy), 64'd0);
        set_valid(1'b0);
        tick();
        chk("bp_idle_after", 64'(m_busy), 64'd0);

        // Reset while in WAIT abandons the op.
        sel = 1'b1; req_op = OP_WRITE; req_key = 2'd2; req_data = 32'h01020304;
        {kp, ns, nf, nd} = 4'b0000;
        set_valid(1'b1);
        tick();
        set_valid(1'b0);
        chk("wait_busy", 64'(m_busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_wait_req_ready", 64'(m_req_ready), 64'd1);
        chk("rst_wait_rsp_valid", 64'(m_rsp_valid), 64'd0);
        chk("rst_wait_ctl_op", 64'(m_ctl_op), 64'd0);
        bad = 1'b0;
        repeat (5) begin
            tick();
            if (m_rsp_valid || m_ctl_op != 2'b00 || m_busy) bad = 1'b1;
        end
        chk("rst_wait_quiet", 64'(bad), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
